serial_bit_source: RTL and testbench
====================================

Name: serial_bit_source

Overview:
Parallel-to-serial source that feeds the three-zero detector's bitin input, one bit per clock, MSB first. It accepts words over a valid/ready handshake and streams back-to-back words with no gap. Between words it drives a fixed idle level, so an idle line never looks like a run of zeros to the detector.

Parameters:
WIDTH, 8, bits per loaded word; legal range 2..32.
IDLE_BIT, 1'b1, level driven on bitout when no word is being shifted.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
load_valid  input  1  load_data is offered this cycle
load_ready  output  1  block accepts a word at the next rising edge (combinational)
load_data  input  WIDTH  word to serialise, MSB first
bitout  output  1  serial bit (registered); connects to detector bitin
bit_valid  output  1  bitout carries word data (registered)
last  output  1  bitout is bit 0 of the current word (registered)
busy  output  1  state is SHIFT (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - bitout=IDLE_BIT, bit_valid=0, last=0, busy=0.
  - load_ready is forced to 0 while reset is low.
- State IDLE:
  - load_ready=1.
  - On a rising edge with load_valid=1, the word is accepted. At that same edge: shift register=load_data, bitout=load_data[WIDTH-1], bit_valid=1, busy=1, counter=0, state goes to SHIFT.
  - Latency from the accepting edge to the first bit appearing on bitout is 0 cycles; the bit is visible right after the edge.
- State SHIFT:
  - Each rising edge shifts left by one and increments the counter. bitout is always the current MSB of the shift register.
  - last=1 exactly while counter==WIDTH-1.
  - load_ready=1 only while counter==WIDTH-1, i.e. during the final bit.
- End of word (edge where counter==WIDTH-1):
  - If load_valid=1, the new word loads exactly as in IDLE: counter=0, state stays SHIFT. There is no idle bit between the words.
  - Otherwise: state=IDLE, bitout=IDLE_BIT, bit_valid=0, last=0, busy=0.
- A word occupies exactly WIDTH consecutive cycles with bit_valid=1.
- load_data is sampled only on a handshake edge; changes at any other time have no effect.
- load_valid=1 while load_ready=0 is ignored and causes no error. The source holds the word until it is accepted.
- Reset asserted mid-word: the word is abandoned immediately and no remaining bits are emitted. After release the block is in IDLE.
- Counter width is $clog2(WIDTH); the counter never wraps past WIDTH-1.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT} with 1-bit encoding.
  - Default idle-level constant.
  - Counter-width function.
- No sub-module: a single always_ff with an asynchronous reset, plus the combinational load_ready.

Test Plan:
- Reset values: hold reset=0, then release mid-cycle. Required: bitout=1, bit_valid=0, busy=0, last=0; load_ready=0 during reset and 1 after release.
- Single word: WIDTH=8, load 8'b1100_1000 from IDLE. Required: bitout=1,1,0,0,1,0,0,0 over 8 cycles with bit_valid=1 and last high on the 8th bit only, then bitout=1 and bit_valid=0.
- Back-to-back: load 8'hA5 with 8'h0F presented during the final bit. Required: 16 contiguous bit_valid cycles carrying 1010_0101_0000_1111; load_ready high only in cycles 0 and 8 relative to the start.
- Ignored offer: hold load_valid=1 with 8'h00 during bits 2-6 of a word. Required: nothing accepted early; 8'h00 loads on the last-bit edge and emits eight 0s.
- Reset mid-word: assert reset at bit 3 of 8'hFF. Required: bitout=1 and bit_valid=0 at once, and the next load streams from its MSB.
- Integration with the detector: stream 8'b0001_1000 and compare the detector's indicator against a golden model. Required: indicator rises only after the third consecutive 0; the idle 1s never trigger it.

Source files
------------

// File: rtl/serial_bit_source_pkg.sv
// Shared types and constants for the serial bit source that feeds the
// three-zero detector.
package serial_bit_source_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Idle level is a one so a quiet line can never look like a zero run.
    localparam logic DEFAULT_IDLE_BIT = 1'b1;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source, MSB first, with gapless back-to-back words and a
// fixed idle level between words.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no word in flight, bitout at IDLE_BIT, ready for a new word
//   ST_SHIFT | shifting a word out; ready again only during its final bit
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = DEFAULT_IDLE_BIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             bitout,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);

    localparam int            CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_CNT = CW'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             accept;

    assign at_last    = (state == ST_SHIFT) && (cnt == LAST_CNT);
    assign load_ready = reset && ((state == ST_IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    // A load at the end of a word takes priority over returning to idle,
    // which is what keeps consecutive words free of an idle bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            bitout    <= IDLE_BIT;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= ST_SHIFT;
            shreg     <= load_data;
            cnt       <= '0;
            bitout    <= load_data[WIDTH-1];
            bit_valid <= 1'b1;
            last      <= 1'b0;
            busy      <= 1'b1;
        end else if (at_last) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            bitout    <= IDLE_BIT;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
        end else if (state == ST_SHIFT) begin
            shreg     <= {shreg[WIDTH-2:0], 1'b0};
            bitout    <= shreg[WIDTH-2];
            cnt       <= cnt + CW'(1);
            last      <= (cnt == PENULT_CNT);
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Scoreboard bench for serial_bit_source: accepted words push their expected
// bits, the negedge monitor pops and compares every valid bit.
module tb_serial_bit_source;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic             bitout;
    logic             bit_valid;
    logic             last;
    logic             busy;

    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    logic [1:0] exp_q[$];

    always #5 clock = ~clock;

    serial_bit_source #(.WIDTH(WIDTH), .IDLE_BIT(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bitout     (bitout),
        .bit_valid  (bit_valid),
        .last       (last),
        .busy       (busy)
    );

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--)
            exp_q.push_back({w[i], (i == 0)});
    endtask

    always @(negedge clock) begin : monitor
        logic [1:0] e;
        if (mon_en) begin
            tests++;
            if (bit_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_bit: bit_valid=1 bitout=%b with no word pending", bitout);
                end else begin
                    e = exp_q.pop_front();
                    if ({bitout, last, busy} !== {e, 1'b1}) begin
                        fails++;
                        $display("FAIL stream_bit @%0t: {bitout,last,busy}=%b expected %b",
                                 $time, {bitout, last, busy}, {e, 1'b1});
                    end
                end
            end else if ({bitout, last, busy, bit_valid} !== 4'b1000) begin
                fails++;
                $display("FAIL idle_level @%0t: {bitout,last,busy,bit_valid}=%b expected 1000",
                         $time, {bitout, last, busy, bit_valid});
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] w, input int budget);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = w;
        for (int c = 0; c < budget && !ok; c++) begin
            if (c > 0) @(negedge clock);
            if (load_ready === 1'b1) begin
                @(posedge clock);
                push_word(w);
                #1;
                load_valid = 1'b0;
                ok = 1'b1;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            load_valid = 1'b0;
            $display("FAIL send_timeout: word %h not accepted within %0d cycles", w, budget);
        end
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: %0d bits still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (load_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_reset: load_ready=%b required 0", load_ready);
        end
        tests++;
        if ({bitout, bit_valid, busy, last} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_outputs: {bitout,bit_valid,busy,last}=%b required 1000",
                     {bitout, bit_valid, busy, last});
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (load_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release: load_ready=%b required 1", load_ready);
        end
        tests++;
        if ({bitout, bit_valid, busy, last} !== 4'b1000) begin
            fails++;
            $display("FAIL release_outputs: {bitout,bit_valid,busy,last}=%b required 1000",
                     {bitout, bit_valid, busy, last});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_word;
        send(8'b1100_1000, 4);
        tests++;
        if ({bitout, bit_valid} !== 2'b11) begin
            fails++;
            $display("FAIL zero_latency: {bitout,bit_valid}=%b required 11", {bitout, bit_valid});
        end
        repeat (9) @(negedge clock);
        #1;
        tests++;
        if ({bitout, bit_valid} !== 2'b10) begin
            fails++;
            $display("FAIL single_end: {bitout,bit_valid}=%b required 10", {bitout, bit_valid});
        end
        check_drained("single");
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = 8'hA5;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) @(negedge clock);
            tests++;
            if (load_ready !== (c == 0 || c == 8 || c >= 16)) begin
                fails++;
                $display("FAIL b2b_ready cycle %0d: load_ready=%b required %b",
                         c, load_ready, (c == 0 || c == 8 || c >= 16));
            end
            tests++;
            if (bit_valid !== (c >= 1 && c <= 16)) begin
                fails++;
                $display("FAIL b2b_valid cycle %0d: bit_valid=%b required %b",
                         c, bit_valid, (c >= 1 && c <= 16));
            end
            if (c == 0 || c == 8) begin
                @(posedge clock);
                push_word((c == 0) ? 8'hA5 : 8'h0F);
                #1;
                if (c == 0) load_data = 8'h0F;
                else        load_valid = 1'b0;
            end
        end
        check_drained("b2b");
    endtask

    task automatic test_ignored_offer;
        send(8'hB3, 4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 2) begin
                load_valid = 1'b1;
                load_data  = 8'h00;
            end
            tests++;
            if (load_ready !== (k == 8)) begin
                fails++;
                $display("FAIL ign_ready bit %0d: load_ready=%b required %b", k, load_ready, (k == 8));
            end
            if (k == 8) begin
                @(posedge clock);
                push_word(8'h00);
                #1;
                load_valid = 1'b0;
            end
        end
        repeat (9) @(negedge clock);
        #1;
        tests++;
        if (bit_valid !== 1'b0) begin
            fails++;
            $display("FAIL ign_end: bit_valid=%b required 0", bit_valid);
        end
        check_drained("ignored");
    endtask

    task automatic test_reset_mid_word;
        send(8'hFF, 4);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        tests++;
        if ({bitout, bit_valid, busy, last, load_ready} !== 5'b10000) begin
            fails++;
            $display("FAIL mid_reset: {bitout,bit_valid,busy,last,load_ready}=%b required 10000",
                     {bitout, bit_valid, busy, last, load_ready});
        end
        @(negedge clock);
        #2 reset = 1'b1;
        send(8'h5A, 4);
        tests++;
        if ({bitout, bit_valid} !== 2'b01) begin
            fails++;
            $display("FAIL post_reset_msb: {bitout,bit_valid}=%b required 01", {bitout, bit_valid});
        end
        repeat (9) @(negedge clock);
        check_drained("mid_reset");
    endtask

    // Behavioural three-zero detector watching bitout every cycle.
    task automatic test_detector_integration;
        logic [15:0] exp_ind;
        int          zrun;
        logic        ind;
        exp_ind = 16'h0840;
        zrun    = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            zrun = (bitout === 1'b0) ? zrun + 1 : 0;
            ind  = (zrun >= 3);
            tests++;
            if (ind !== exp_ind[c]) begin
                fails++;
                $display("FAIL detector cycle %0d: indicator=%b required %b", c, ind, exp_ind[c]);
            end
            if (c == 3) begin
                load_valid = 1'b1;
                load_data  = 8'b0001_1000;
                @(posedge clock);
                push_word(8'b0001_1000);
                #1;
                load_valid = 1'b0;
            end
        end
        check_drained("detector");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignored_offer();
        test_reset_mid_word();
        test_detector_integration();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
